// File: rtl/usb_pkg.sv
// Shared USB transmit definitions: packet type codes, scheduler state encoding,
// and small helpers used by the scheduler and the byte transmitter.
package usb_pkg;

  localparam logic [3:0] BAG_ACK    = 4'd1;
  localparam logic [3:0] BAG_NAK    = 4'd2;
  localparam logic [3:0] BAG_STL    = 4'd3;
  localparam logic [3:0] BAG_DIDX   = 4'd5;
  localparam logic [3:0] BAG_DPARAM = 4'd6;
  localparam logic [3:0] BAG_DDIDX  = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_START, ST_RELEASE, ST_ABORT, ST_GAP
  } sched_state_t;

  typedef struct packed {
    logic [3:0]  btype;
    logic [31:0] data;
  } cmd_entry_t;

  function automatic logic cmd_type_legal(input logic [3:0] t);
    return (t == BAG_DIDX) || (t == BAG_DPARAM) || (t == BAG_DDIDX);
  endfunction

  // Pending handshake codes equal the low bits of BAG_ACK/NAK/STL, so priority is a max.
  function automatic logic [1:0] hs_merge(input logic [1:0] held, input logic ack,
                                          input logic nak, input logic stl);
    logic [1:0] req;
    req = stl ? 2'd3 : (nak ? 2'd2 : (ack ? 2'd1 : 2'd0));
    return (req > held) ? req : held;
  endfunction

endpackage

// File: rtl/usb_cmd_fifo.sv
// Synchronous FIFO holding queued {type,data} command entries for the scheduler.
module usb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot the same cycle, so a full FIFO still accepts a push.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/usb_tx_sched.sv
// Upstream scheduler for the USB byte transmitter: handshake slot, command queue,
// fs/fd handshake with timeout recovery and inter-packet gap.
//   state   | meaning
//   IDLE    | nothing in flight, waiting for handshake or command
//   LOAD    | latch btype/data_cmd (handshake first, else FIFO head)
//   START   | fs high, waiting for fd rise or timeout
//   RELEASE | fs low, waiting for fd to fall
//   ABORT   | transmitter hung, packet discarded
//   GAP     | idle spacing before the next fs
module usb_tx_sched
  import usb_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 255,
  parameter int GAP       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ack_req,
  input  logic        nak_req,
  input  logic        stl_req,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_type,
  input  logic [31:0] cmd_data,
  output logic        fs,
  input  logic        fd,
  output logic [3:0]  btype,
  output logic [31:0] data_cmd,
  output logic        busy,
  output logic        sent,
  output logic        err_type,
  output logic        err_tout
);
  localparam int TMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TOUT_LD = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'((GAP > 0) ? GAP - 1 : 0);

  sched_state_t state;
  logic [1:0]   hs_pend;
  logic [TW-1:0] tmr;
  logic         armed;
  logic         fifo_full, fifo_empty, fifo_pop;
  logic         push_ok, push_bad, any_hs;
  cmd_entry_t   fifo_head;

  assign cmd_ready = !fifo_full;
  assign push_ok   = cmd_valid && cmd_ready && cmd_type_legal(cmd_type);
  assign push_bad  = cmd_valid && cmd_ready && !cmd_type_legal(cmd_type);
  assign any_hs    = ack_req || nak_req || stl_req;
  assign fifo_pop  = (state == ST_LOAD) && (hs_pend == 2'd0);

  usb_cmd_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(36)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .wdata ({cmd_type, cmd_data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_pend  <= 2'd0;
      err_type <= 1'b0;
    end else begin
      err_type <= push_bad;
      if (state == ST_LOAD && hs_pend != 2'd0)
        hs_pend <= hs_merge(2'd0, ack_req, nak_req, stl_req);
      else
        hs_pend <= hs_merge(hs_pend, ack_req, nak_req, stl_req);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      fs       <= 1'b0;
      btype    <= 4'd0;
      data_cmd <= 32'd0;
      busy     <= 1'b0;
      sent     <= 1'b0;
      err_tout <= 1'b0;
      tmr      <= '0;
      armed    <= 1'b0;
    end else begin
      sent     <= 1'b0;
      err_tout <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Incoming requests count too, so fs rises two cycles after the request.
          if (hs_pend != 2'd0 || !fifo_empty || any_hs || push_ok) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          tmr   <= TOUT_LD;
          armed <= 1'b0;
          if (hs_pend != 2'd0) begin
            btype    <= {2'b00, hs_pend};
            data_cmd <= 32'd0;
            fs       <= 1'b1;
            state    <= ST_START;
          end else if (!fifo_empty) begin
            btype    <= fifo_head.btype;
            data_cmd <= fifo_head.data;
            fs       <= 1'b1;
            state    <= ST_START;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_START: begin
          // A stale fd left over from a previous packet must drop before it counts.
          if (!fd) armed <= 1'b1;
          if (armed && fd) begin
            fs    <= 1'b0;
            state <= ST_RELEASE;
          end else if (tmr == '0) begin
            fs       <= 1'b0;
            err_tout <= 1'b1;
            state    <= ST_ABORT;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!fd) begin
            sent <= 1'b1;
            if (GAP == 0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              tmr   <= GAP_LD;
              state <= ST_GAP;
            end
          end
        end
        ST_ABORT: begin
          if (GAP == 0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            tmr   <= GAP_LD;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          fs    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_sched.sv
// Directed bench for usb_tx_sched with a transmitter model that answers fs after N cycles.
module tb_usb_tx_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        ack_req, nak_req, stl_req;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_type;
  logic [31:0] cmd_data;
  logic        fs, fd;
  logic [3:0]  btype;
  logic [31:0] data_cmd;
  logic        busy, sent, err_type, err_tout;

  int n_tests = 0;
  int n_fail  = 0;

  logic fd_en;
  int   fd_n;
  int   fd_cnt;

  usb_tx_sched #(.CMD_DEPTH(4), .TIMEOUT(16), .GAP(2)) dut (
    .clk(clk), .rst(rst), .ack_req(ack_req), .nak_req(nak_req), .stl_req(stl_req),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_data(cmd_data),
    .fs(fs), .fd(fd), .btype(btype), .data_cmd(data_cmd), .busy(busy), .sent(sent),
    .err_type(err_type), .err_tout(err_tout)
  );

  always #5 clk = ~clk;

  // Transmitter model: raise fd fd_n cycles after seeing fs, hold until fs drops.
  always @(posedge clk) begin
    if (!rst || !fs) begin
      fd     <= 1'b0;
      fd_cnt <= 0;
    end else if (fd_en && !fd) begin
      if (fd_cnt == fd_n - 1) fd <= 1'b1;
      fd_cnt <= fd_cnt + 1;
    end
  end

  typedef struct {
    logic        valid;
    logic [3:0]  ctype;
    logic [31:0] cdata;
    logic        ack, nak, stl;
    logic        exp_pkt;
    logic [3:0]  exp_btype;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] t, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_pkt(input string nm, input logic [3:0] eb, input logic [31:0] ed);
    int k;
    logic stable;
    k = 0;
    while (!fs && k < 60) begin tick(); k++; end
    check({nm, " fs_rise"}, 64'(fs), 64'd1);
    check({nm, " btype"}, 64'(btype), 64'(eb));
    check({nm, " data_cmd"}, 64'(data_cmd), 64'(ed));
    stable = 1'b1;
    k = 0;
    while (!sent && k < 100) begin
      if (btype !== eb || data_cmd !== ed) stable = 1'b0;
      tick();
      k++;
    end
    check({nm, " sent"}, 64'(sent), 64'd1);
    check({nm, " stable"}, 64'(stable), 64'd1);
  endtask

  task automatic expect_quiet(input string nm, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (fs) seen = 1'b1;
    end
    check(nm, 64'(seen), 64'd0);
  endtask

  initial begin
    int hi, k;
    vecs[0] = '{1'b1, 4'd6, 32'h0012_3000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 32'h0012_3000, 1'b0};
    vecs[1] = '{1'b1, 4'd5, 32'h0A5B_C000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 32'h0A5B_C000, 1'b0};
    vecs[2] = '{1'b1, 4'd7, 32'hFFFF_F000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 32'hFFFF_F000, 1'b0};
    vecs[3] = '{1'b0, 4'd0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 32'h0,         1'b0};
    vecs[4] = '{1'b0, 4'd0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 32'h0,         1'b0};
    vecs[5] = '{1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'h0,         1'b0};
    vecs[6] = '{1'b0, 4'd0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h0,         1'b0};
    vecs[7] = '{1'b0, 4'd0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 32'h0,         1'b0};
    vecs[8] = '{1'b1, 4'h4, 32'h1234_5000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,         1'b1};
    vecs[9] = '{1'b1, 4'h0, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,         1'b1};

    rst = 1'b0; ack_req = 0; nak_req = 0; stl_req = 0;
    cmd_valid = 0; cmd_type = 4'd0; cmd_data = 32'd0;
    fd_en = 1'b1; fd_n = 8;
    repeat (3) @(posedge clk);
    #1;
    check("rst fs", 64'(fs), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst btype", 64'(btype), 64'd0);
    check("rst data_cmd", 64'(data_cmd), 64'd0);
    check("rst pulses", 64'({sent, err_type, err_tout}), 64'd0);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      cmd_valid = vecs[i].valid; cmd_type = vecs[i].ctype; cmd_data = vecs[i].cdata;
      ack_req = vecs[i].ack; nak_req = vecs[i].nak; stl_req = vecs[i].stl;
      tick();
      cmd_valid = 0; ack_req = 0; nak_req = 0; stl_req = 0;
      check($sformatf("v%0d err_type", i), 64'(err_type), 64'(vecs[i].exp_err));
      check($sformatf("v%0d fs_early", i), 64'(fs), 64'd0);
      tick();
      check($sformatf("v%0d fs_latency", i), 64'(fs), 64'(vecs[i].exp_pkt));
      if (vecs[i].exp_pkt) begin
        wait_pkt($sformatf("v%0d", i), vecs[i].exp_btype, vecs[i].exp_data);
        tick();
        check($sformatf("v%0d sent_one_cycle", i), 64'(sent), 64'd0);
        check($sformatf("v%0d busy_gap", i), 64'(busy), 64'd1);
        tick();
        check($sformatf("v%0d busy_end", i), 64'(busy), 64'd0);
      end else begin
        check($sformatf("v%0d busy", i), 64'(busy), 64'd0);
        check($sformatf("v%0d cmd_ready", i), 64'(cmd_ready), 64'd1);
        expect_quiet($sformatf("v%0d no_pkt", i), 6);
      end
    end

    // Handshake and command in the same cycle: handshake goes first.
    ack_req = 1'b1;
    push(4'd5, 32'h0000_5000);
    ack_req = 1'b0;
    wait_pkt("t3 ack", 4'd1, 32'd0);
    wait_pkt("t3 didx", 4'd5, 32'h0000_5000);
    repeat (4) tick();

    // ACK then STL while busy: only STL survives.
    push(4'd6, 32'h0006_6000);
    tick();
    ack_req = 1'b1; tick(); ack_req = 1'b0;
    tick();
    stl_req = 1'b1; tick(); stl_req = 1'b0;
    wait_pkt("t4 cmd", 4'd6, 32'h0006_6000);
    wait_pkt("t4 stl", 4'd3, 32'd0);
    expect_quiet("t4 no_ack", 25);

    // Hung transmitter: fill FIFO behind it, then timeout and drain.
    fd_en = 1'b0;
    push(4'd6, 32'h0000_C000);
    tick();
    check("t5 c0 fs", 64'(fs), 64'd1);
    hi = fs ? 1 : 0;
    for (int i = 1; i <= 5; i++) begin
      cmd_valid = 1'b1; cmd_type = 4'd5; cmd_data = 32'(i) << 12;
      check($sformatf("t5 ready_push%0d", i), 64'(cmd_ready), (i <= 4) ? 64'd1 : 64'd0);
      tick();
      if (fs) hi++;
    end
    cmd_valid = 1'b0;
    k = 0;
    while (fs && k < 40) begin tick(); k++; if (fs) hi++; end
    check("t6 fs_high_cycles", 64'(hi), 64'd16);
    check("t6 err_tout", 64'(err_tout), 64'd1);
    check("t6 no_sent", 64'(sent), 64'd0);
    tick();
    check("t6 err_tout_pulse", 64'(err_tout), 64'd0);
    fd_en = 1'b1;
    for (int i = 1; i <= 4; i++)
      wait_pkt($sformatf("t5 drain%0d", i), 4'd5, 32'(i) << 12);
    expect_quiet("t5 fifth_dropped", 25);
    check("t5 ready_after", 64'(cmd_ready), 64'd1);

    // Reset in the middle of a packet with commands still queued.
    push(4'd7, 32'h0000_7000);
    push(4'd7, 32'h0000_8000);
    push(4'd7, 32'h0000_9000);
    check("t1 fs_before", 64'(fs), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("t1 fs_async", 64'(fs), 64'd0);
    check("t1 busy_async", 64'(busy), 64'd0);
    check("t1 ready_async", 64'(cmd_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    expect_quiet("t1 fifo_flushed", 20);
    check("t1 busy_after", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
